// File: rtl/dll_pkg.sv
// Shared DLL definitions: controller states, fine-line thermometer width and
// the level-to-thermometer mapping used by the fine and coarse controllers.
package dll_pkg;
  localparam int THERM_W = 6;
  localparam int LVL_W   = $clog2(THERM_W + 1);

  typedef enum logic [1:0] {
    ST_TRACK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } dll_state_e;

  // Level n becomes n ones packed against the MSB.
  function automatic logic [THERM_W-1:0] lvl2therm(input logic [LVL_W-1:0] lvl);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_W; i++)
      if (i < int'(lvl)) t[THERM_W-1-i] = 1'b1;
    return t;
  endfunction
endpackage

// File: rtl/dll_fine_ctrl_if.sv
// Phase-detector input and fine/coarse delay-line control bundle.
interface dll_fine_ctrl_if;
  import dll_pkg::*;
  logic               pd_valid;
  logic               pd_up;
  logic               pd_dn;
  logic               hold;
  logic [THERM_W-1:0] q;
  logic               coarse_inc;
  logic               coarse_dec;
  logic               locked;

  modport master (output pd_valid, pd_up, pd_dn, hold,
                  input  q, coarse_inc, coarse_dec, locked);
  modport slave  (input  pd_valid, pd_up, pd_dn, hold,
                  output q, coarse_inc, coarse_dec, locked);
endinterface

// File: rtl/dll_lock_det.sv
// Lock detector: counts direction reversals between successive fine steps.
module dll_lock_det #(
  parameter int LOCK_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  input  logic dir_up_i,
  input  logic wrap_i,
  output logic locked_o
);
  localparam int RC_W = $clog2(LOCK_CNT + 1);

  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic            prev_up_q, prev_up_d;
  logic            have_prev_q, have_prev_d;
  logic            locked_q, locked_d;

  always_comb begin
    rcnt_d      = rcnt_q;
    prev_up_d   = prev_up_q;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    if (step_i) begin
      prev_up_d   = dir_up_i;
      have_prev_d = 1'b1;
      if (wrap_i) begin
        rcnt_d   = '0;
        locked_d = 1'b0;
      end else if (have_prev_q && (dir_up_i != prev_up_q)) begin
        if (rcnt_q != RC_W'(LOCK_CNT)) rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q >= RC_W'(LOCK_CNT - 1)) locked_d = 1'b1;
      end else if (have_prev_q) begin
        // Repeating the previous direction means two same-direction steps in a row.
        rcnt_d   = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q      <= '0;
      prev_up_q   <= 1'b0;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      rcnt_q      <= rcnt_d;
      prev_up_q   <= prev_up_d;
      have_prev_q <= have_prev_d;
      locked_q    <= locked_d;
    end
  end

  assign locked_o = locked_q;
endmodule

// File: rtl/dll_fine_ctrl.sv
// Fine delay-line controller: steps a thermometer code from phase-detector samples and
// carries into the coarse line on wrap. Define FDL_CTRL_FILTER_EN for the up/down vote filter.
module dll_fine_ctrl
  import dll_pkg::*;
#(
  parameter int FILT_DEPTH = 4,
  parameter int SETTLE_CYC = 3,
  parameter int LOCK_CNT   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dll_fine_ctrl_if.slave bus
);
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  if (FILT_DEPTH < 1 || SETTLE_CYC < 1 || LOCK_CNT < 1) begin : g_bad_param
    $error("dll_fine_ctrl: FILT_DEPTH, SETTLE_CYC and LOCK_CNT must be >= 1");
  end

  dll_state_e         state_q, state_d;
  logic [SC_W-1:0]    scnt_q, scnt_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [THERM_W-1:0] q_q;
  logic               cinc_q, cinc_d, cdec_q, cdec_d;
  logic               take, step_up, step_dn, locked;

  // Equal up/dn votes carry no phase information and are dropped here.
  assign take = bus.pd_valid & ~bus.hold & (state_q != ST_SETTLE) & (bus.pd_up ^ bus.pd_dn);

`ifdef FDL_CTRL_FILTER_EN
  localparam int ACC_W = $clog2(FILT_DEPTH + 1) + 1;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  int                      acc_nxt;

  // Hitting either bound fires a step and clears, so the clamp is implicit.
  always_comb begin
    acc_d   = acc_q;
    acc_nxt = int'(acc_q);
    step_up = 1'b0;
    step_dn = 1'b0;
    if (bus.hold) begin
      acc_d = '0;
    end else if (take) begin
      acc_nxt = int'(acc_q) + (bus.pd_up ? 1 : -1);
      if (acc_nxt >= FILT_DEPTH) begin
        step_up = 1'b1;
        acc_d   = '0;
      end else if (acc_nxt <= -FILT_DEPTH) begin
        step_dn = 1'b1;
        acc_d   = '0;
      end else begin
        acc_d = ACC_W'(acc_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  assign step_up = take & bus.pd_up;
  assign step_dn = take & bus.pd_dn;
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    lvl_d   = lvl_q;
    cinc_d  = 1'b0;
    cdec_d  = 1'b0;
    if (step_up || step_dn) begin
      if (step_up) begin
        if (lvl_q == LVL_W'(THERM_W)) begin
          lvl_d  = '0;
          cinc_d = 1'b1;
        end else begin
          lvl_d = lvl_q + 1'b1;
        end
      end else begin
        if (lvl_q == '0) begin
          lvl_d  = LVL_W'(THERM_W);
          cdec_d = 1'b1;
        end else begin
          lvl_d = lvl_q - 1'b1;
        end
      end
      state_d = ST_SETTLE;
      scnt_d  = SC_W'(SETTLE_CYC - 1);
    end else if (state_q == ST_SETTLE && !bus.hold) begin
      if (scnt_q == '0) state_d = locked ? ST_LOCKED : ST_TRACK;
      else              scnt_d  = scnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_TRACK;
      scnt_q  <= '0;
      lvl_q   <= LVL_W'(3);
      q_q     <= lvl2therm(LVL_W'(3));
      cinc_q  <= 1'b0;
      cdec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      lvl_q   <= lvl_d;
      q_q     <= lvl2therm(lvl_d);
      cinc_q  <= cinc_d;
      cdec_q  <= cdec_d;
    end
  end

  dll_lock_det #(.LOCK_CNT(LOCK_CNT)) u_lock (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_i   (step_up | step_dn),
    .dir_up_i (step_up),
    .wrap_i   (cinc_d | cdec_d),
    .locked_o (locked)
  );

  assign bus.q          = q_q;
  assign bus.coarse_inc = cinc_q;
  assign bus.coarse_dec = cdec_q;
  assign bus.locked     = locked;
endmodule

// File: tb/tb_dll_fine_ctrl.sv
// Randomized bench for dll_fine_ctrl against a cycle-level behavioural model.
module tb_dll_fine_ctrl;
  import dll_pkg::*;
  localparam int FD = 4, SC = 3, LC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  dll_fine_ctrl_if bus();

  dll_fine_ctrl #(.FILT_DEPTH(FD), .SETTLE_CYC(SC), .LOCK_CNT(LC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Model state in plain integers.
  int m_lvl, m_settle, m_acc, m_rev, m_prev;
  bit m_have, m_locked, m_inc, m_dec, m_stepped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] therm(input int l);
    logic [5:0] all1;
    all1 = '1;
    return ~(all1 >> l);
  endfunction

  task automatic model_reset();
    m_lvl = 3; m_settle = 0; m_acc = 0; m_rev = 0; m_prev = 0;
    m_have = 0; m_locked = 0; m_inc = 0; m_dec = 0; m_stepped = 0;
  endtask

  task automatic model_step(input bit v, input bit u, input bit d, input bit h);
    int dir;
    bit go, wrap;
    m_inc = 0; m_dec = 0; m_stepped = 0;
    if (h) m_acc = 0;
    else if (m_settle > 0) m_settle--;
    else if (v && (u != d)) begin
      dir = u ? 1 : -1;
`ifdef FDL_CTRL_FILTER_EN
      m_acc += dir;
      go = (m_acc >= FD) || (m_acc <= -FD);
      if (go) m_acc = 0;
`else
      go = 1;
`endif
      if (go) begin
        m_stepped = 1;
        wrap = 0;
        m_lvl += dir;
        if (m_lvl > 6) begin m_lvl = 0; m_inc = 1; wrap = 1; end
        if (m_lvl < 0) begin m_lvl = 6; m_dec = 1; wrap = 1; end
        m_settle = SC;
        if (wrap) begin
          m_rev = 0; m_locked = 0;
        end else if (m_have && dir != m_prev) begin
          if (m_rev < LC) m_rev++;
          if (m_rev == LC) m_locked = 1;
        end else if (m_have) begin
          m_rev = 0; m_locked = 0;
        end
        m_prev = dir; m_have = 1;
      end
    end
  endtask

  task automatic cyc(input bit v, input bit u, input bit d, input bit h);
    bus.pd_valid = v; bus.pd_up = u; bus.pd_dn = d; bus.hold = h;
    @(posedge clk);
    model_step(v, u, d, h);
    #1;
    chk("q", bus.q, therm(m_lvl));
    chk("coarse_inc", bus.coarse_inc, m_inc);
    chk("coarse_dec", bus.coarse_dec, m_dec);
    chk("locked", bus.locked, m_locked);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_q", bus.q, 6'b111000);
    chk("rst_inc", bus.coarse_inc, 0);
    chk("rst_dec", bus.coarse_dec, 0);
    chk("rst_locked", bus.locked, 0);
    bus.pd_valid = 0; bus.pd_up = 0; bus.pd_dn = 0; bus.hold = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic one_step(input bit up);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc(1, up, !up, 0);
      ok = m_stepped;
    end
    if (!ok) chk("step_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] hq;
    int bias;
    bit v, u, d, h;
    bus.pd_valid = 0; bus.pd_up = 0; bus.pd_dn = 0; bus.hold = 0;
    model_reset();
    #7;
    do_reset();

    // Continuous up samples: step timing, settle blanking, then wrap.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 0);
`ifdef FDL_CTRL_FILTER_EN
      if (i == 2) chk("filt_pre", bus.q, 6'b111000);
      if (i == 3) chk("filt_step", bus.q, 6'b111100);
      if (i == 6) chk("filt_settle", bus.q, 6'b111100);
`else
      if (i == 0)  chk("step_s1", bus.q, 6'b111100);
      if (i == 4)  chk("step_s2", bus.q, 6'b111110);
      if (i == 8)  chk("step_s3", bus.q, 6'b111111);
      if (i == 12) chk("wrap_q", bus.q, 6'b000000);
      if (i == 12) chk("wrap_inc", bus.coarse_inc, 1);
      if (i == 13) chk("wrap_inc_w", bus.coarse_inc, 0);
`endif
    end
    repeat (60) cyc(1, 1, 0, 0);
    repeat (90) cyc(1, 0, 1, 0);

    // Lock acquisition and loss.
    do_reset();
    for (int s = 0; s < 9; s++) begin
      one_step(s % 2 == 0);
      repeat (SC) cyc(0, 0, 0, 0);
      if (s == 7) chk("lock_7rev", bus.locked, 0);
    end
    chk("lock_on", bus.locked, 1);
    one_step(0); repeat (SC) cyc(0, 0, 0, 0);
    chk("lock_rev_keep", bus.locked, 1);
    one_step(0); repeat (SC) cyc(0, 0, 0, 0);
    chk("lock_off", bus.locked, 0);

    // Hold freezes everything and discards partial accumulation.
    do_reset();
    repeat (3) cyc(1, 1, 0, 0);
    hq = therm(m_lvl);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 1);
      chk("hold_q", bus.q, hq);
      chk("hold_nopulse", bus.coarse_inc | bus.coarse_dec, 0);
    end
`ifdef FDL_CTRL_FILTER_EN
    repeat (3) cyc(1, 1, 0, 0);
    chk("hold_fresh3", bus.q, 6'b111000);
    cyc(1, 1, 0, 0);
    chk("hold_fresh4", bus.q, 6'b111100);
`else
    chk("hold_kept", bus.q, 6'b111100);
    repeat (4) cyc(1, 1, 0, 0);
    chk("hold_resume", bus.q, 6'b111110);
`endif
    // Both-votes samples are no-ops.
    repeat (10) cyc(1, 1, 1, 0);

    // Reset while settling.
    do_reset();
    repeat (SC + 1) cyc(0, 0, 0, 0);
    one_step(1);
    chk("settle_pre", bus.q, 6'b111100);
    cyc(0, 0, 0, 0);
    do_reset();
    repeat (SC + 2) cyc(0, 0, 0, 0);

    // Randomized segments with varying direction bias.
    for (int seg = 0; seg < 15; seg++) begin
      if (seg % 5 == 4) do_reset();
      bias = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        v = ($urandom_range(0, 99) < 70);
        h = ($urandom_range(0, 99) < 6);
        case ($urandom_range(0, 9))
          0: begin u = 1; d = 1; end
          1: begin u = 0; d = 0; end
          default: begin u = ($urandom_range(0, 99) < bias); d = !u; end
        endcase
        cyc(v, u, d, h);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
